// File: rtl/cmp_pkg.sv
// cmp_pkg: shared constants, FSM state encoding and id-width helper used by
// cmp_arbiter and its round-robin picker.
package cmp_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int NREQ_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } cmp_state_t;

  // Width of a requester index; at least one bit even for tiny NREQ.
  function automatic int cmp_idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/comp_32.sv
// comp_32: shared magnitude comparator core (unsigned compare of a and b).
module comp_32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search. Starting at ptr and walking
// upward with wrap, the first set bit of valid wins. Produces a one-hot
// grant, the encoded winner id and an any-valid flag.
module rr_pick
  import cmp_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = cmp_idw(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id,
  output logic            any
);

  logic [IDW-1:0] slot;
  logic           hit;
  logic           found;

  // Visit slots ptr, ptr+1, ... (mod NREQ); only the first valid slot is granted.
  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    slot  = '0;
    hit   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      slot        = IDW'((int'(ptr) + i) % NREQ);
      hit         = valid[slot] & ~found;
      grant[slot] = hit;
      id          = hit ? slot : id;
      found       = found | hit;
    end
    any = found;
  end

endmodule

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin arbiter/sequencer sharing one comp_32 among NREQ
// requesters. Grant in IDLE (or on a RESP handshake), compare in CMP, hold
// the tagged result in RESP until the consumer takes it. Accept-to-result
// latency is 2 cycles.
// Optional feature: define CMP_SIGNED_EN to add the per-requester req_signed
// input selecting a two's-complement compare.
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int NREQ  = NREQ_DEF,
  localparam int IDW   = cmp_idw(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
`ifdef CMP_SIGNED_EN
  input  logic [NREQ-1:0]       req_signed,
`endif
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_lt,
  output logic [WIDTH-1:0]      rsp_eq,
  output logic [WIDTH-1:0]      rsp_gt,
  output logic                  busy
);

  cmp_state_t     state_r;
  cmp_state_t     state_next;

  logic [IDW-1:0] ptr_r;
  logic [IDW-1:0] ptr_inc_s;
  logic [IDW-1:0] pick_ptr_s;
  logic           hs_s;
  logic           take_s;

  logic [NREQ-1:0] pick_grant_s;
  logic [IDW-1:0]  pick_id_s;
  logic            pick_any_s;

  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [IDW-1:0]   op_id_r;
  logic             sgn_s;

  logic [WIDTH-1:0] cmp_a_s;
  logic [WIDTH-1:0] cmp_b_s;
  logic             cmp_lt_s;
  logic             cmp_eq_s;
  logic             cmp_gt_s;

  logic             res_lt_r;
  logic             res_eq_r;
  logic             res_gt_r;
  logic [IDW-1:0]   rsp_id_r;
  logic             rsp_valid_r;
  logic             busy_r;

  // Result handshake, and the pointer that follows the owner of the result.
  assign hs_s      = (state_r == RESP) && rsp_ready;
  assign ptr_inc_s = (rsp_id_r == IDW'(NREQ - 1)) ? '0 : rsp_id_r + IDW'(1);

  // On a handshake the search already starts from the advanced pointer.
  assign pick_ptr_s = hs_s ? ptr_inc_s : ptr_r;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (pick_ptr_s),
    .grant (pick_grant_s),
    .id    (pick_id_s),
    .any   (pick_any_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next state and grant decision; grants happen only from IDLE or on a RESP handshake.
  always_comb begin
    state_next = state_r;
    take_s     = 1'b0;
    req_ready  = '0;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          take_s     = 1'b1;
          state_next = CMP;
        end else begin
          state_next = IDLE;
        end
      end
      CMP: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (pick_any_s) begin
            take_s     = 1'b1;
            state_next = CMP;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = RESP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Reset forces the accept strobe low even though state already reads IDLE.
    req_ready = (take_s && rst_n) ? pick_grant_s : '0;
  end

  // Operand capture at grant; the id travels with the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_r  <= '0;
      op_b_r  <= '0;
      op_id_r <= '0;
    end else if (take_s) begin
      op_a_r  <= req_a[int'(pick_id_s) * WIDTH +: WIDTH];
      op_b_r  <= req_b[int'(pick_id_s) * WIDTH +: WIDTH];
      op_id_r <= pick_id_s;
    end else begin
      op_a_r  <= op_a_r;
      op_b_r  <= op_b_r;
      op_id_r <= op_id_r;
    end
  end

`ifdef CMP_SIGNED_EN
  logic op_sgn_r;

  // Capture the requester's signed-mode bit alongside its operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_sgn_r <= 1'b0;
    end else if (take_s) begin
      op_sgn_r <= req_signed[pick_id_s];
    end else begin
      op_sgn_r <= op_sgn_r;
    end
  end

  assign sgn_s = op_sgn_r;
`else
  assign sgn_s = 1'b0;
`endif

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  assign cmp_a_s = op_a_r ^ {sgn_s, {(WIDTH-1){1'b0}}};
  assign cmp_b_s = op_b_r ^ {sgn_s, {(WIDTH-1){1'b0}}};

  comp_32 #(
    .WIDTH (WIDTH)
  ) u_comp (
    .a  (cmp_a_s),
    .b  (cmp_b_s),
    .lt (cmp_lt_s),
    .eq (cmp_eq_s),
    .gt (cmp_gt_s)
  );

  // Result capture in CMP; values then stay frozen through RESP and beyond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_lt_r <= 1'b0;
      res_eq_r <= 1'b0;
      res_gt_r <= 1'b0;
      rsp_id_r <= '0;
    end else if (state_r == CMP) begin
      res_lt_r <= cmp_lt_s;
      res_eq_r <= cmp_eq_s;
      res_gt_r <= cmp_gt_s;
      rsp_id_r <= op_id_r;
    end else begin
      res_lt_r <= res_lt_r;
      res_eq_r <= res_eq_r;
      res_gt_r <= res_gt_r;
      rsp_id_r <= rsp_id_r;
    end
  end

  // Pointer advances to just past the owner of the result on each handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (hs_s) begin
      ptr_r <= ptr_inc_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Status flags registered from the next state so they leave the block as flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      rsp_valid_r <= (state_next == RESP);
      busy_r      <= (state_next != IDLE);
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_lt    = {{(WIDTH-1){1'b0}}, res_lt_r};
  assign rsp_eq    = {{(WIDTH-1){1'b0}}, res_eq_r};
  assign rsp_gt    = {{(WIDTH-1){1'b0}}, res_gt_r};
  assign busy      = busy_r;

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: scoreboard bench for cmp_arbiter. Each accepted request
// pushes its modelled result; each result handshake pops and compares.
module tb_cmp_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = 2;

  typedef struct {
    int           id;
    logic [W-1:0] lt;
    logic [W-1:0] eq;
    logic [W-1:0] gt;
    int           acc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_signed;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_lt;
  logic [W-1:0]   rsp_eq;
  logic [W-1:0]   rsp_gt;
  logic           busy;

  exp_t         exp_q[$];
  int           grant_log[$];
  int           gcyc_log[$];
  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  bit           prev_vld = 1'b0;
  int           pend[N];
  bit           acc_now[N];
  logic [W-1:0] last_lt[N];
  logic [W-1:0] last_eq[N];
  logic [W-1:0] last_gt[N];
  logic         sgn_bit;

  always #5 clk = ~clk;

  cmp_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef CMP_SIGNED_EN
    .req_signed(req_signed),
`endif
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_lt    (rsp_lt),
    .rsp_eq    (rsp_eq),
    .rsp_gt    (rsp_gt),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input int acc);
    exp_t e;
    logic l;
    logic g;
    if (s) begin
      l = ($signed(a) < $signed(b));
      g = ($signed(a) > $signed(b));
    end else begin
      l = (a < b);
      g = (a > b);
    end
    e.id  = id;
    e.lt  = {{(W-1){1'b0}}, l};
    e.eq  = {{(W-1){1'b0}}, (a == b)};
    e.gt  = {{(W-1){1'b0}}, g};
    e.acc = acc;
    return e;
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input int more);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_signed[i]   = s;
    pend[i]         = more;
    req_valid[i]    = 1'b1;
  endtask

  // Negedge monitor: scoreboard push on accept, pop/compare on result handshake.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) acc_now[i] = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      prev_vld = 1'b0;
    end else begin
      check("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      if (rsp_valid && !prev_vld) begin
        if (exp_q.size() == 0) check("rsp_unrequested", 64'd1, 64'd0);
        else check("latency", 64'(cyc - exp_q[0].acc), 64'd2);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_spurious", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(e.id));
          check("rsp_lt", 64'(rsp_lt), 64'(e.lt));
          check("rsp_eq", 64'(rsp_eq), 64'(e.eq));
          check("rsp_gt", 64'(rsp_gt), 64'(e.gt));
          last_lt[e.id] = rsp_lt;
          last_eq[e.id] = rsp_eq;
          last_gt[e.id] = rsp_gt;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back(model(i, req_a[i*W +: W], req_b[i*W +: W], req_signed[i], cyc));
          grant_log.push_back(i);
          gcyc_log.push_back(cyc);
          acc_now[i] = 1'b1;
        end
      end
      prev_vld = rsp_valid;
    end
  endtask

  // Posedge driver: accepted requesters either present a fresh pair or drop valid.
  task automatic drive_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_now[i]) begin
        if (pend[i] > 0) begin
          pend[i]--;
          req_a[i*W +: W] = $urandom;
          req_b[i*W +: W] = ($urandom_range(0, 3) == 0) ? req_a[i*W +: W] : $urandom;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    sample();
    drive_edge();
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while ((req_valid != '0 || exp_q.size() != 0 || busy) && k < limit) begin
      tick();
      k++;
    end
    check("drain_idle", 64'(req_valid != '0 || exp_q.size() != 0 || busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_signed = '0;
    rsp_ready  = 1'b1;
    for (int i = 0; i < N; i++) begin
      pend[i]    = 0;
      acc_now[i] = 1'b0;
    end
    repeat (3) tick();

    // Reset state
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_lt", 64'(rsp_lt), 64'd0);
    check("rst_rsp_eq", 64'(rsp_eq), 64'd0);
    check("rst_rsp_gt", 64'(rsp_gt), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    // Single request: 5 vs 9 from requester 0
    set_req(0, 32'd5, 32'd9, 1'b0, 0);
    sample();
    check("t1_ready", 64'(req_ready), 64'h1);
    drive_edge();
    sample();
    check("t1_ready_cmp", 64'(req_ready), 64'h0);
    check("t1_busy_cmp", 64'(busy), 64'd1);
    check("t1_valid_early", 64'(rsp_valid), 64'd0);
    drive_edge();
    sample();
    check("t1_valid", 64'(rsp_valid), 64'd1);
    check("t1_id", 64'(rsp_id), 64'd0);
    check("t1_lt", 64'(rsp_lt), 64'h1);
    check("t1_eq", 64'(rsp_eq), 64'h0);
    check("t1_gt", 64'(rsp_gt), 64'h0);
    drive_edge();
    sample();
    check("t1_valid_clear", 64'(rsp_valid), 64'd0);
    drive_edge();

    // All four requesters valid from reset, two requests each
    rst_n = 1'b0;
    tick();
    tick();
    grant_log.delete();
    gcyc_log.delete();
    for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom, 1'b0, 1);
    #1;
    check("rst_ready_masked", 64'(req_ready), 64'h0);
    rst_n = 1'b1;
    drain(60);
    check("t2_grant_count", 64'(grant_log.size()), 64'd8);
    if (grant_log.size() >= 8) begin
      for (int k = 0; k < 8; k++) check("t2_order", 64'(grant_log[k]), 64'(k % N));
      for (int k = 1; k < 8; k++) check("t2_spacing", 64'(gcyc_log[k] - gcyc_log[k-1]), 64'd2);
    end

    // Backpressure in RESP while requester 2 waits
    rsp_ready = 1'b0;
    set_req(0, 32'd7, 32'd7, 1'b0, 0);
    tick();
    set_req(2, 32'd1, 32'd2, 1'b0, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      sample();
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_id", 64'(rsp_id), 64'd0);
      check("bp_eq", 64'(rsp_eq), 64'h1);
      check("bp_lt", 64'(rsp_lt), 64'h0);
      check("bp_gt", 64'(rsp_gt), 64'h0);
      check("bp_ready", 64'(req_ready), 64'h0);
      drive_edge();
    end
    rsp_ready = 1'b1;
    sample();
    check("bp_grant_hs", 64'(req_ready), 64'h4);
    drive_edge();
    drain(20);

    // Edge operands
`ifdef CMP_SIGNED_EN
    sgn_bit = 1'b1;
`else
    sgn_bit = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      last_lt[i] = 'x;
      last_eq[i] = 'x;
      last_gt[i] = 'x;
    end
    set_req(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 0);
    set_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    set_req(3, 32'h8000_0000, 32'h0000_0001, sgn_bit, 0);
    drain(30);
    check("edge_ones_eq", 64'(last_eq[1]), 64'h1);
    check("edge_ones_lt", 64'(last_lt[1]), 64'h0);
    check("edge_unsigned_gt", 64'(last_gt[0]), 64'h1);
    check("edge_unsigned_lt", 64'(last_lt[0]), 64'h0);
`ifdef CMP_SIGNED_EN
    check("edge_signed_lt", 64'(last_lt[3]), 64'h1);
    check("edge_signed_gt", 64'(last_gt[3]), 64'h0);
`else
    check("edge_req3_gt", 64'(last_gt[3]), 64'h1);
`endif

    // Reset during CMP discards the in-flight compare
    set_req(0, 32'd3, 32'd4, 1'b0, 0);
    tick();
    check("t5_busy_cmp", 64'(busy), 64'd1);
    set_req(1, 32'd9, 32'd2, 1'b0, 0);
    set_req(3, 32'd6, 32'd6, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(rsp_valid), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_ready", 64'(req_ready), 64'h0);
    tick();
    check("t5_rst_valid_hold", 64'(rsp_valid), 64'd0);
    tick();
    grant_log.delete();
    gcyc_log.delete();
    rst_n = 1'b1;
    sample();
    check("t5_first_grant", 64'(req_ready), 64'h2);
    drive_edge();
    drain(30);
    check("t5_grant_count", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() >= 2) begin
      check("t5_order0", 64'(grant_log[0]), 64'd1);
      check("t5_order1", 64'(grant_log[1]), 64'd3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
